load_data_checker: RTL and testbench
====================================

LOAD_DATA_CHECKER -- requirements
Module: load_data_checker

Interface
REQ-001 SHALL have parameter HEAD, default 32'h5716EB90: expected packet header.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1024: maximum idle cycles allowed between words inside a packet.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 clr  in  1  synchronous clear of statistics counters.
REQ-006 din  in  16  descrambled packet word from the load data generator.
REQ-007 din_en  in  1  din valid; no backpressure.
REQ-008 pkt_done  out  1  one-cycle pulse when a packet finishes or is aborted.
REQ-009 pkt_ok  out  1  valid with pkt_done; 1 means no error.
REQ-010 err_flags  out  4  valid with pkt_done: [0] payload, [1] CRC, [2] sequence, [3] length/timeout.
REQ-011 last_count  out  24; last_flag  out  16; last_length  out  24: header fields of the last packet.
REQ-012 pkt_total, pkt_bad, seq_err_cnt  out  32 each: statistics counters.

Function
REQ-013 Word order SHALL be HEAD[31:16], HEAD[15:0], count[23:8], {count[7:0],flag[15:8]}, {flag[7:0],len[23:16]}, len[15:0], payload, CRC.
REQ-014 Only cycles with din_en=1 SHALL advance parsing; gaps of any length up to TIMEOUT are legal.
REQ-015 FSM states: HUNT0, HUNT1, CNT_HI, CNT_LO, LEN_HI, LEN_LO, PAYLOAD, CRC, REPORT.
REQ-016 In HUNT0, go to HUNT1 on din==HEAD[31:16]; otherwise stay.
REQ-017 In HUNT1, go to CNT_HI on din==HEAD[15:0]; stay in HUNT1 on din==HEAD[31:16]; otherwise go to HUNT0.
REQ-018 CNT_HI, CNT_LO, LEN_HI, LEN_LO SHALL each capture one word.
REQ-019 Expected payload words SHALL be ceil((len-14)/2), computed in 24 bits.
REQ-020 If len<14, set err[3] and go to REPORT; if len==14, skip PAYLOAD and go to CRC.
REQ-021 Payload word k (k from 0) SHALL equal {(2k)[7:0], (2k+1)[7:0]}, wrapping every 128 words.
REQ-022 Any payload mismatch SHALL set err[0]; the rest of the payload is still consumed.
REQ-023 The first din_en word after the last payload word SHALL be taken as the CRC.
REQ-024 CRC check: CRC-16 polynomial 0x1021, init 0x0000, MSB-first, over all header and payload words; mismatch sets err[1].
REQ-025 Sequence check SHALL require count == previous count+1 mod 2^24; a failure sets err[2].
REQ-026 The sequence check SHALL be skipped for the first packet after reset or after an abort.
REQ-027 Idle-cycle counter: in any state other than HUNT0, HUNT1 or REPORT, reaching TIMEOUT consecutive cycles with din_en=0 SHALL set err[3] and go to REPORT.
REQ-028 An abort (timeout or len<14) SHALL also invalidate the previous-count reference.
REQ-029 REPORT lasts one cycle: pkt_done=1, pkt_ok=(err_flags==0), last_* updated, counters updated, then HUNT0.
REQ-030 din_en is ignored during REPORT; the generator's inter-packet gap of at least 3 cycles guarantees no loss.
REQ-031 pkt_total increments on every REPORT; pkt_bad when any error bit is set; seq_err_cnt on err[2].
REQ-032 All statistics counters wrap modulo 2^32.
REQ-033 If clr coincides with REPORT, clr SHALL win and the counters read 0.
REQ-034 Latency: pkt_done SHALL assert on the cycle after the CRC word is sampled.

Reset
REQ-035 nRST low SHALL force state HUNT0 and zero all outputs, counters, the error accumulator, the CRC register and the previous-count reference.
REQ-036 Reset mid-packet SHALL discard the packet without a pkt_done pulse.

Structure
REQ-037 Shared package SHALL hold: state encoding, the HEAD default, the header word count (6), the length overhead constant (14) and the CRC polynomial.
REQ-038 The CRC SHALL be a sub-module crc16_ccitt_word (ports: clk, nRST, init, en, din[15:0], crc[15:0]), reused by sibling blocks.

Verification
REQ-039 Two back-to-back packets with count 0 and 1, len=30 (8 payload words), correct CRC -> two pkt_ok pulses, pkt_total=2, pkt_bad=0.
REQ-040 Payload word 3 corrupted to 16'hFFFF -> pkt_done with err_flags=4'b0001, pkt_bad=1.
REQ-041 Counts 5 then 7 -> second packet gives err_flags[2]=1, seq_err_cnt=1.
REQ-042 Noise word 16'h5716 before a valid header -> packet still locks and is checked ok.
REQ-043 len=14 -> zero payload words, CRC checked, pkt_ok=1; len=10 -> err_flags=4'b1000.
REQ-044 din_en held low for 1024 cycles mid-payload -> timeout report with err[3]=1; the next packet is not sequence-checked.

Source files
------------

// File: rtl/load_data_checker_pkg.sv
// Shared definitions for the load data checker and its CRC sub-module:
// FSM state encoding, packet framing constants and the CRC-16 word step.
package load_data_checker_pkg;

    typedef enum logic [3:0] {
        HUNT0, HUNT1, CNT_HI, CNT_LO, LEN_HI, LEN_LO, PAYLOAD, CRC, REPORT
    } state_e;

    localparam logic [31:0] HEAD_DEFAULT = 32'h5716EB90;
    localparam int          HDR_WORDS    = 6;
    // Header bytes plus the two CRC bytes: a packet with no payload has len 14.
    localparam logic [23:0] LEN_OVERHEAD = 24'(2 * HDR_WORDS + 2);
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'h0000;

    // One 16-bit word through CRC-16, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_word.sv
// Word-wide CRC-16 (poly 0x1021, MSB first) accumulator.
// Ports: clk, nRST (async active-low), init (restart from CRC_INIT),
//        en (absorb din this cycle), din[15:0], crc[15:0] (running value).
// init together with en restarts the CRC with din as the first word.
module crc16_ccitt_word
    import load_data_checker_pkg::*;
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] base;

    assign base = init ? CRC_INIT : crc_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)     crc_q <= CRC_INIT;
        else if (en)   crc_q <= crc16_step(base, din);
        else if (init) crc_q <= CRC_INIT;
    end

    assign crc = crc_q;

endmodule

// File: rtl/load_data_checker.sv
// Checks packets from the load data generator: locks on the header, captures
// count/flag/length, verifies the counting payload pattern, CRC and sequence,
// flags idle timeouts, and keeps statistics.
// Ports: clk, nRST (async active-low), clr (sync counter clear),
//        din/din_en (word stream, no backpressure),
//        pkt_done/pkt_ok/err_flags (per-packet report, one cycle),
//        last_count/last_flag/last_length (header of last packet),
//        pkt_total/pkt_bad/seq_err_cnt (wrapping statistics).
module load_data_checker
    import load_data_checker_pkg::*;
#(
    parameter logic [31:0] HEAD    = HEAD_DEFAULT,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        clr,
    input  logic [15:0] din,
    input  logic        din_en,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [3:0]  err_flags,
    output logic [23:0] last_count,
    output logic [15:0] last_flag,
    output logic [23:0] last_length,
    output logic [31:0] pkt_total,
    output logic [31:0] pkt_bad,
    output logic [31:0] seq_err_cnt
);

    state_e      state_q, state_d;
    logic [15:0] idle_q, idle_d;
    logic [3:0]  err_q, err_d;
    logic [23:0] cnt_q, cnt_d, len_q, len_d, rem_q, rem_d, prev_cnt_q, prev_cnt_d;
    logic [15:0] flag_q, flag_d;
    logic [6:0]  pidx_q, pidx_d;
    logic        prev_vld_q, prev_vld_d;
    logic [23:0] last_count_q, last_count_d, last_length_q, last_length_d;
    logic [15:0] last_flag_q, last_flag_d;
    logic [31:0] total_q, total_d, bad_q, bad_d, seqerr_q, seqerr_d;
    logic        crc_init, crc_en, timeout, in_pkt;
    logic [15:0] crc_val;
    logic [23:0] new_len;

    crc16_ccitt_word u_crc (
        .clk (clk),
        .nRST(nRST),
        .init(crc_init),
        .en  (crc_en),
        .din (din),
        .crc (crc_val)
    );

    assign in_pkt  = !(state_q inside {HUNT0, HUNT1, REPORT});
    assign new_len = {len_q[23:16], din};

    always_comb begin
        state_d       = state_q;
        idle_d        = '0;
        err_d         = err_q;
        cnt_d         = cnt_q;
        flag_d        = flag_q;
        len_d         = len_q;
        rem_d         = rem_q;
        pidx_d        = pidx_q;
        prev_cnt_d    = prev_cnt_q;
        prev_vld_d    = prev_vld_q;
        last_count_d  = last_count_q;
        last_flag_d   = last_flag_q;
        last_length_d = last_length_q;
        total_d       = total_q;
        bad_d         = bad_q;
        seqerr_d      = seqerr_q;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        timeout       = 1'b0;

        if (in_pkt && !din_en) begin
            idle_d  = idle_q + 16'd1;
            timeout = (idle_q == TIMEOUT - 16'd1);
        end

        case (state_q)
            HUNT0: if (din_en) begin
                // Every hunted word restarts the CRC so it holds HEAD[31:16] on lock.
                crc_init = 1'b1;
                crc_en   = 1'b1;
                if (din == HEAD[31:16]) state_d = HUNT1;
            end
            HUNT1: if (din_en) begin
                crc_en = 1'b1;
                if (din == HEAD[15:0]) state_d = CNT_HI;
                else begin
                    crc_init = 1'b1;
                    state_d  = (din == HEAD[31:16]) ? HUNT1 : HUNT0;
                end
            end
            CNT_HI: if (din_en) begin
                crc_en      = 1'b1;
                cnt_d[23:8] = din;
                state_d     = CNT_LO;
            end
            CNT_LO: if (din_en) begin
                crc_en       = 1'b1;
                cnt_d[7:0]   = din[15:8];
                flag_d[15:8] = din[7:0];
                if (prev_vld_q && ({cnt_q[23:8], din[15:8]} != prev_cnt_q + 24'd1))
                    err_d[2] = 1'b1;
                state_d = LEN_HI;
            end
            LEN_HI: if (din_en) begin
                crc_en        = 1'b1;
                flag_d[7:0]   = din[15:8];
                len_d[23:16]  = din[7:0];
                state_d       = LEN_LO;
            end
            LEN_LO: if (din_en) begin
                crc_en      = 1'b1;
                len_d[15:0] = din;
                if (new_len < LEN_OVERHEAD) begin
                    err_d[3] = 1'b1;
                    state_d  = REPORT;
                end else if (new_len == LEN_OVERHEAD) begin
                    state_d = CRC;
                end else begin
                    // ceil((len-14)/2) without leaving 24 bits
                    rem_d   = (new_len - LEN_OVERHEAD + 24'd1) >> 1;
                    pidx_d  = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (din_en) begin
                crc_en = 1'b1;
                // 7-bit index gives the 128-word wrap of the byte pattern for free
                if (din != {pidx_q, 1'b0, pidx_q, 1'b1}) err_d[0] = 1'b1;
                pidx_d = pidx_q + 7'd1;
                rem_d  = rem_q - 24'd1;
                if (rem_q == 24'd1) state_d = CRC;
            end
            CRC: if (din_en) begin
                if (din != crc_val) err_d[1] = 1'b1;
                state_d = REPORT;
            end
            REPORT: begin
                state_d       = HUNT0;
                err_d         = '0;
                last_count_d  = cnt_q;
                last_flag_d   = flag_q;
                last_length_d = len_q;
                prev_cnt_d    = cnt_q;
                // Aborted packets leave no trustworthy count reference.
                prev_vld_d    = !err_q[3];
                total_d       = total_q + 32'd1;
                bad_d         = bad_q + {31'd0, |err_q};
                seqerr_d      = seqerr_q + {31'd0, err_q[2]};
            end
            default: state_d = HUNT0;
        endcase

        if (timeout) begin
            err_d[3] = 1'b1;
            state_d  = REPORT;
        end

        if (clr) begin
            total_d  = '0;
            bad_d    = '0;
            seqerr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= HUNT0;
            idle_q        <= '0;
            err_q         <= '0;
            cnt_q         <= '0;
            flag_q        <= '0;
            len_q         <= '0;
            rem_q         <= '0;
            pidx_q        <= '0;
            prev_cnt_q    <= '0;
            prev_vld_q    <= 1'b0;
            last_count_q  <= '0;
            last_flag_q   <= '0;
            last_length_q <= '0;
            total_q       <= '0;
            bad_q         <= '0;
            seqerr_q      <= '0;
        end else begin
            state_q       <= state_d;
            idle_q        <= idle_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            flag_q        <= flag_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            pidx_q        <= pidx_d;
            prev_cnt_q    <= prev_cnt_d;
            prev_vld_q    <= prev_vld_d;
            last_count_q  <= last_count_d;
            last_flag_q   <= last_flag_d;
            last_length_q <= last_length_d;
            total_q       <= total_d;
            bad_q         <= bad_d;
            seqerr_q      <= seqerr_d;
        end
    end

    assign pkt_done    = (state_q == REPORT);
    assign pkt_ok      = pkt_done && (err_q == 4'd0);
    assign err_flags   = pkt_done ? err_q : 4'd0;
    assign last_count  = last_count_q;
    assign last_flag   = last_flag_q;
    assign last_length = last_length_q;
    assign pkt_total   = total_q;
    assign pkt_bad     = bad_q;
    assign seq_err_cnt = seqerr_q;

endmodule

// File: tb/tb_load_data_checker.sv
module tb_load_data_checker;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] din = '0;
    logic        din_en = 1'b0;
    logic        pkt_done, pkt_ok;
    logic [3:0]  err_flags;
    logic [23:0] last_count, last_length;
    logic [15:0] last_flag;
    logic [31:0] pkt_total, pkt_bad, seq_err_cnt;

    int errs = 0;
    int checks = 0;

    load_data_checker dut (
        .clk(clk), .nRST(nRST), .clr(clr), .din(din), .din_en(din_en),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_flags(err_flags),
        .last_count(last_count), .last_flag(last_flag), .last_length(last_length),
        .pkt_total(pkt_total), .pkt_bad(pkt_bad), .seq_err_cnt(seq_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 15; i >= 0; i--)
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    function automatic logic [15:0] pay_word(input int k);
        logic [7:0] a, b;
        a = 8'(2 * k);
        b = 8'(2 * k + 1);
        return {a, b};
    endfunction

    task automatic send_word(input logic [15:0] w, input int gap);
        din_en = 1'b0;
        repeat (gap) tick();
        din = w;
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
    endtask

    // stop_after >= 0 sends only the header and that many payload words.
    task automatic send_pkt(input logic [23:0] cnt, input logic [15:0] flag, input logic [23:0] len,
                            input int bad_k, input int gap, input int stop_after);
        logic [15:0] w[$];
        logic [15:0] c;
        int np;
        w.push_back(16'h5716);
        w.push_back(16'hEB90);
        w.push_back(cnt[23:8]);
        w.push_back({cnt[7:0], flag[15:8]});
        w.push_back({flag[7:0], len[23:16]});
        w.push_back(len[15:0]);
        if (len >= 24'd14) begin
            np = (int'(len) - 14 + 1) / 2;
            if (stop_after >= 0) np = stop_after;
            for (int k = 0; k < np; k++) w.push_back((k == bad_k) ? 16'hFFFF : pay_word(k));
            if (stop_after < 0) begin
                c = 16'h0000;
                foreach (w[i]) c = ref_crc(c, w[i]);
                w.push_back(c);
            end
        end
        foreach (w[i]) send_word(w[i], gap);
    endtask

    task automatic test_reset();
        int seen;
        tick(); tick();
        checks++; if (pkt_done !== 1'b0 || err_flags !== 4'd0 || pkt_ok !== 1'b0) begin errs++;
            $display("FAIL reset_report: done=%b ok=%b err=%b want 0", pkt_done, pkt_ok, err_flags); end
        checks++; if (pkt_total !== 32'd0 || pkt_bad !== 32'd0 || seq_err_cnt !== 32'd0) begin errs++;
            $display("FAIL reset_counters: %0d %0d %0d want 0", pkt_total, pkt_bad, seq_err_cnt); end
        checks++; if (last_count !== 24'd0 || last_flag !== 16'd0 || last_length !== 24'd0) begin errs++;
            $display("FAIL reset_last: %h %h %h want 0", last_count, last_flag, last_length); end
        nRST = 1'b1;
        tick();
        send_word(16'h5716, 0); send_word(16'hEB90, 0); send_word(16'h0000, 0);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        seen = 0;
        repeat (20) begin tick(); if (pkt_done) seen++; end
        checks++; if (seen !== 0 || pkt_total !== 32'd0) begin errs++;
            $display("FAIL reset_midpkt: pulses=%0d total=%0d want 0 0", seen, pkt_total); end
    endtask

    task automatic test_back_to_back();
        send_pkt(24'd0, 16'hA5C3, 24'd30, -1, 0, -1);
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL b2b_pkt0: done=%b ok=%b err=%b want 1 1 0000", pkt_done, pkt_ok, err_flags); end
        tick();
        checks++; if (pkt_done !== 1'b0) begin errs++;
            $display("FAIL b2b_pulse_width: done=%b want 0", pkt_done); end
        repeat (3) tick();
        send_pkt(24'd1, 16'hA5C3, 24'd30, -1, 0, -1);
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL b2b_pkt1: done=%b ok=%b err=%b want 1 1 0000", pkt_done, pkt_ok, err_flags); end
        tick();
        checks++; if (pkt_total !== 32'd2 || pkt_bad !== 32'd0) begin errs++;
            $display("FAIL b2b_counters: total=%0d bad=%0d want 2 0", pkt_total, pkt_bad); end
        checks++; if (last_count !== 24'd1 || last_flag !== 16'hA5C3 || last_length !== 24'd30) begin errs++;
            $display("FAIL b2b_last: %h %h %h want 000001 a5c3 00001e", last_count, last_flag, last_length); end
        repeat (3) tick();
    endtask

    task automatic test_payload_err();
        send_pkt(24'd2, 16'h0102, 24'd30, 3, 0, -1);
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b0 || err_flags !== 4'b0001) begin errs++;
            $display("FAIL payload_err: done=%b ok=%b err=%b want 1 0 0001", pkt_done, pkt_ok, err_flags); end
        tick();
        checks++; if (pkt_bad !== 32'd1 || pkt_total !== 32'd3) begin errs++;
            $display("FAIL payload_cnt: bad=%0d total=%0d want 1 3", pkt_bad, pkt_total); end
        repeat (3) tick();
    endtask

    task automatic test_noise_lock();
        send_word(16'h1234, 0);
        send_word(16'h5716, 0);
        send_pkt(24'd3, 16'hBEEF, 24'd21, -1, 2, -1);
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL noise_lock: done=%b ok=%b err=%b want 1 1 0000", pkt_done, pkt_ok, err_flags); end
        tick();
        checks++; if (last_count !== 24'd3 || last_length !== 24'd21 || last_flag !== 16'hBEEF) begin errs++;
            $display("FAIL noise_last: %h %h %h want 000003 beef 000015", last_count, last_flag, last_length); end
        repeat (3) tick();
    endtask

    task automatic test_len14();
        send_pkt(24'd4, 16'h0000, 24'd14, -1, 0, -1);
        checks++; if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL len14: done=%b ok=%b err=%b want 1 1 0000", pkt_done, pkt_ok, err_flags); end
        tick();
        checks++; if (last_length !== 24'd14 || pkt_total !== 32'd5) begin errs++;
            $display("FAIL len14_last: len=%0d total=%0d want 14 5", last_length, pkt_total); end
        repeat (3) tick();
    endtask

    task automatic test_sequence();
        send_pkt(24'd5, 16'h1111, 24'd16, -1, 0, -1);
        checks++; if (pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL seq_first: ok=%b err=%b want 1 0000", pkt_ok, err_flags); end
        repeat (4) tick();
        send_pkt(24'd7, 16'h1111, 24'd16, -1, 0, -1);
        checks++; if (pkt_done !== 1'b1 || err_flags !== 4'b0100) begin errs++;
            $display("FAIL seq_gap: done=%b err=%b want 1 0100", pkt_done, err_flags); end
        tick();
        checks++; if (seq_err_cnt !== 32'd1 || pkt_bad !== 32'd2 || pkt_total !== 32'd7) begin errs++;
            $display("FAIL seq_counters: seq=%0d bad=%0d total=%0d want 1 2 7", seq_err_cnt, pkt_bad, pkt_total); end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int n;
        // count 8 follows 7, so only the timeout bit may appear
        send_pkt(24'd8, 16'h2222, 24'd30, -1, 0, 3);
        n = 0;
        while (!pkt_done && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1024) begin errs++;
            $display("FAIL timeout_latency: idle cycles=%0d want 1024", n); end
        checks++; if (pkt_done !== 1'b1 || err_flags !== 4'b1000 || pkt_ok !== 1'b0) begin errs++;
            $display("FAIL timeout_flags: done=%b ok=%b err=%b want 1 0 1000", pkt_done, pkt_ok, err_flags); end
        repeat (4) tick();
        send_pkt(24'd200, 16'h3333, 24'd18, -1, 0, -1);
        checks++; if (pkt_ok !== 1'b1 || err_flags !== 4'd0) begin errs++;
            $display("FAIL timeout_noseq: ok=%b err=%b want 1 0000", pkt_ok, err_flags); end
        tick();
        checks++; if (pkt_total !== 32'd9 || pkt_bad !== 32'd3 || seq_err_cnt !== 32'd1) begin errs++;
            $display("FAIL timeout_counters: %0d %0d %0d want 9 3 1", pkt_total, pkt_bad, seq_err_cnt); end
        repeat (3) tick();
    endtask

    task automatic test_short_len();
        send_pkt(24'd201, 16'h4444, 24'd10, -1, 0, -1);
        checks++; if (pkt_done !== 1'b1 || err_flags !== 4'b1000) begin errs++;
            $display("FAIL len10: done=%b err=%b want 1 1000", pkt_done, err_flags); end
        tick();
        checks++; if (pkt_bad !== 32'd4 || pkt_total !== 32'd10) begin errs++;
            $display("FAIL len10_counters: bad=%0d total=%0d want 4 10", pkt_bad, pkt_total); end
        repeat (3) tick();
    endtask

    task automatic test_clear();
        // count 500 would be a sequence error if len10 had kept the reference
        send_pkt(24'd500, 16'h5555, 24'd20, -1, 0, -1);
        checks++; if (pkt_ok !== 1'b1) begin errs++;
            $display("FAIL clr_pkt: ok=%b want 1", pkt_ok); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (pkt_total !== 32'd0 || pkt_bad !== 32'd0 || seq_err_cnt !== 32'd0) begin errs++;
            $display("FAIL clr_wins: %0d %0d %0d want 0 0 0", pkt_total, pkt_bad, seq_err_cnt); end
        repeat (3) tick();
        send_pkt(24'd501, 16'h5555, 24'd20, -1, 0, -1);
        tick();
        checks++; if (pkt_total !== 32'd1 || pkt_bad !== 32'd0 || last_count !== 24'd501) begin errs++;
            $display("FAIL clr_after: total=%0d bad=%0d cnt=%0d want 1 0 501", pkt_total, pkt_bad, last_count); end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_payload_err();
        test_noise_lock();
        test_len14();
        test_sequence();
        test_timeout();
        test_short_len();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
